// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_direct #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_USED  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        fetch_start,
  input  logic [31:0] pc,
  output logic        finish_fetch,
  output logic [31:0] instruction_out,
  output logic [31:0] instruction_pc_out,
  output logic        mem_fetch_start,
  output logic [31:0] mem_pc,
  input  logic        mem_finish,
  input  logic [31:0] mem_instruction
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_USED - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic                valid_r [LINES];
  logic [TAG_W-1:0]    tag_r   [LINES];
  logic [31:0]         data_r  [LINES];

  logic [29:0]         lat_pc_r, lat_pc_s;
  logic [INDEX_BITS-1:0] index_s, lat_index_s;
  logic [TAG_W-1:0]    pc_tag_s, lat_tag_s;
  logic                hit_s;
  logic                refill_s;
  logic                acc_hit_s, acc_miss_s;
  logic                finish_s, mfs_s;
  logic [31:0]         instr_s, ipc_s, mpc_s;
  logic                unused_s;

  assign unused_s    = ^pc[1:0];
  assign index_s     = pc[INDEX_BITS+1:2];
  assign pc_tag_s    = pc[ADDR_USED-1:INDEX_BITS+2];
  assign lat_index_s = lat_pc_r[INDEX_BITS-1:0];
  assign lat_tag_s   = lat_pc_r[ADDR_USED-3:INDEX_BITS];
  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == pc_tag_s);

  // Next-state and next-output logic; roll_back overrides every state.
  always_comb begin
    state_s    = state_r;
    lat_pc_s   = lat_pc_r;
    finish_s   = 1'b0;
    instr_s    = instruction_out;
    ipc_s      = instruction_pc_out;
    mfs_s      = mem_fetch_start;
    mpc_s      = mem_pc;
    refill_s   = 1'b0;
    acc_hit_s  = 1'b0;
    acc_miss_s = 1'b0;
    if (roll_back) begin
      state_s = IDLE;
      mfs_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fetch_start) begin
            if (hit_s) begin
              acc_hit_s = 1'b1;
              finish_s  = 1'b1;
              instr_s   = data_r[index_s];
              ipc_s     = {pc[31:2], 2'b00};
            end else begin
              acc_miss_s = 1'b1;
              mfs_s      = 1'b1;
              mpc_s      = {pc[31:2], 2'b00};
              lat_pc_s   = pc[31:2];
              state_s    = MISS;
            end
          end else begin
            state_s = IDLE;
          end
        end
        MISS: begin
          if (mem_finish) begin
            refill_s = 1'b1;
            finish_s = 1'b1;
            instr_s  = mem_instruction;
            ipc_s    = {lat_pc_r, 2'b00};
            mfs_s    = 1'b0;
            state_s  = IDLE;
          end else begin
            state_s = MISS;
          end
        end
        default: begin
          state_s = IDLE;
          mfs_s   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r            <= IDLE;
      lat_pc_r           <= 30'd0;
      finish_fetch       <= 1'b0;
      instruction_out    <= 32'd0;
      instruction_pc_out <= 32'd0;
      mem_fetch_start    <= 1'b0;
      mem_pc             <= 32'd0;
    end else if (rdy_in) begin
      state_r            <= state_s;
      lat_pc_r           <= lat_pc_s;
      finish_fetch       <= finish_s;
      instruction_out    <= instr_s;
      instruction_pc_out <= ipc_s;
      mem_fetch_start    <= mfs_s;
      mem_pc             <= mpc_s;
    end
  end

  // Valid bits: cleared on reset, set on refill.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < LINES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (rdy_in && refill_s) begin
      valid_r[lat_index_s] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && refill_s) begin
      tag_r[lat_index_s]  <= lat_tag_s;
      data_r[lat_index_s] <= mem_instruction;
    end
  end

`ifdef ICACHE_PERF_EN
  // Accepted-request counters, wrapping modulo 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (rdy_in) begin
      hit_count  <= hit_count + {31'd0, acc_hit_s};
      miss_count <= miss_count + {31'd0, acc_miss_s};
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed literal checks plus randomized traffic
// compared every cycle against a behavioural cache model.
module tb_icache_direct;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, fetch_start, mem_finish;
  logic [31:0] pc, mem_instruction;
  logic        finish_fetch, mem_fetch_start;
  logic [31:0] instruction_out, instruction_pc_out, mem_pc;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  icache_direct dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .fetch_start(fetch_start), .pc(pc), .finish_fetch(finish_fetch),
    .instruction_out(instruction_out), .instruction_pc_out(instruction_pc_out),
    .mem_fetch_start(mem_fetch_start), .mem_pc(mem_pc),
    .mem_finish(mem_finish), .mem_instruction(mem_instruction)
`ifdef ICACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a table of lines plus "a miss is outstanding".
  bit          m_valid [256];
  logic [7:0]  m_tag   [256];
  logic [31:0] m_data  [256];
  bit          m_pend;
  logic [31:0] m_lpc;
  logic        e_ff, e_mfs;
  logic [31:0] e_instr, e_ipc, e_mpc, e_hits, e_misses;

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 256; i++) m_valid[i] <= 1'b0;
      m_pend <= 1'b0; m_lpc <= 32'd0;
      e_ff <= 1'b0; e_mfs <= 1'b0; e_instr <= 32'd0; e_ipc <= 32'd0; e_mpc <= 32'd0;
      e_hits <= 32'd0; e_misses <= 32'd0;
    end else if (rdy_in) begin
      e_ff <= 1'b0;
      if (roll_back) begin
        m_pend <= 1'b0;
        e_mfs  <= 1'b0;
      end else if (!m_pend) begin
        if (fetch_start) begin
          if (m_valid[pc[9:2]] && m_tag[pc[9:2]] == pc[17:10]) begin
            e_ff    <= 1'b1;
            e_instr <= m_data[pc[9:2]];
            e_ipc   <= pc & 32'hFFFF_FFFC;
            e_hits  <= e_hits + 32'd1;
          end else begin
            m_pend   <= 1'b1;
            m_lpc    <= pc & 32'hFFFF_FFFC;
            e_mfs    <= 1'b1;
            e_mpc    <= pc & 32'hFFFF_FFFC;
            e_misses <= e_misses + 32'd1;
          end
        end
      end else if (mem_finish) begin
        m_valid[m_lpc[9:2]] <= 1'b1;
        m_tag[m_lpc[9:2]]   <= m_lpc[17:10];
        m_data[m_lpc[9:2]]  <= mem_instruction;
        e_ff    <= 1'b1;
        e_instr <= mem_instruction;
        e_ipc   <= m_lpc;
        e_mfs   <= 1'b0;
        m_pend  <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("m_finish_fetch", {31'd0, finish_fetch}, {31'd0, e_ff});
      check("m_instruction_out", instruction_out, e_instr);
      check("m_instruction_pc_out", instruction_pc_out, e_ipc);
      check("m_mem_fetch_start", {31'd0, mem_fetch_start}, {31'd0, e_mfs});
      check("m_mem_pc", mem_pc, e_mpc);
`ifdef ICACHE_PERF_EN
      check("m_hit_count", hit_count, e_hits);
      check("m_miss_count", miss_count, e_misses);
`endif
    end
  end

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_start = 1'b1; pc = a;
    cyc();
    fetch_start = 1'b0;
  endtask

  task automatic refill(input logic [31:0] w, input logic [31:0] a);
    mem_finish = 1'b1; mem_instruction = w;
    cyc();
    mem_finish = 1'b0;
    check("refill_ff", {31'd0, finish_fetch}, 32'd1);
    check("refill_instr", instruction_out, w);
    check("refill_pc", instruction_pc_out, a);
    check("refill_mfs", {31'd0, mem_fetch_start}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; fetch_start = 1'b0;
    pc = 32'd0; mem_finish = 1'b0; mem_instruction = 32'd0;
    cyc();
    chk_en = 1'b1;
    check("rst_ff", {31'd0, finish_fetch}, 32'd0);
    check("rst_mfs", {31'd0, mem_fetch_start}, 32'd0);
    check("rst_mpc", mem_pc, 32'd0);
    check("rst_instr", instruction_out, 32'd0);
    cyc();
    rst_in = 1'b0;

    // Cold miss at pc 0, word returned several cycles later.
    fetch(32'h0000_0000);
    check("cold_mfs", {31'd0, mem_fetch_start}, 32'd1);
    check("cold_mpc", mem_pc, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("cold_hold_mfs", {31'd0, mem_fetch_start}, 32'd1);
      check("cold_hold_ff", {31'd0, finish_fetch}, 32'd0);
    end
    refill(32'h0000_0513, 32'h0000_0000);
    cyc();
    check("pulse_once", {31'd0, finish_fetch}, 32'd0);

    // Hit: one-cycle latency, no memory request.
    fetch(32'h0000_0000);
    check("hit_ff", {31'd0, finish_fetch}, 32'd1);
    check("hit_instr", instruction_out, 32'h0000_0513);
    check("hit_mfs", {31'd0, mem_fetch_start}, 32'd0);

    // Conflict on index 0: 0x400 evicts 0x0 (back-to-back accept).
    fetch(32'h0000_0400);
    check("conf_mfs", {31'd0, mem_fetch_start}, 32'd1);
    check("conf_mpc", mem_pc, 32'h0000_0400);
    refill(32'h1234_5678, 32'h0000_0400);
    fetch(32'h0000_0400);
    check("conf_hit", instruction_out, 32'h1234_5678);
    fetch(32'h0000_0000);
    check("evict_miss", {31'd0, mem_fetch_start}, 32'd1);
    check("evict_noff", {31'd0, finish_fetch}, 32'd0);
    refill(32'h0000_0513, 32'h0000_0000);

    // roll_back together with mem_finish: no response, no refill.
    fetch(32'h0000_0008);
    check("rb_mfs", {31'd0, mem_fetch_start}, 32'd1);
    roll_back = 1'b1; mem_finish = 1'b1; mem_instruction = 32'h0BAD_0BAD;
    cyc();
    roll_back = 1'b0; mem_finish = 1'b0;
    check("rb_ff", {31'd0, finish_fetch}, 32'd0);
    check("rb_mfs_clr", {31'd0, mem_fetch_start}, 32'd0);
    fetch(32'h0000_0008);
    check("rb_remiss", {31'd0, mem_fetch_start}, 32'd1);
    refill(32'h00A0_0093, 32'h0000_0008);

    // rdy_in low mid-miss freezes the request.
    fetch(32'h0000_000C);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_mfs", {31'd0, mem_fetch_start}, 32'd1);
      check("stall_mpc", mem_pc, 32'h0000_000C);
    end
    rdy_in = 1'b1;
    refill(32'h00B0_0113, 32'h0000_000C);

`ifdef ICACHE_PERF_EN
    check("perf_hits", hit_count, 32'd2);
    check("perf_misses", miss_count, 32'd6);
`endif
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    check("rst2_mfs", {31'd0, mem_fetch_start}, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst2_hits", hit_count, 32'd0);
    check("rst2_misses", miss_count, 32'd0);
`endif
    fetch(32'h0000_0000);
    check("rst2_cold", {31'd0, mem_fetch_start}, 32'd1);

    // Random traffic on a small footprint so hits, conflicts and aliases recur.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom;
      pc = r & 32'h0000_0C1F;
      if (r[31:28] == 4'h0) pc[31:18] = r[27:14];
      fetch_start = ($urandom_range(0, 1) == 0);
      roll_back   = ($urandom_range(0, 19) == 0);
      rdy_in      = ($urandom_range(0, 9) != 0);
      rst_in      = ($urandom_range(0, 299) == 0);
      mem_finish  = mem_fetch_start ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      mem_instruction = $urandom;
      cyc();
    end
    rst_in = 1'b0; rdy_in = 1'b1; fetch_start = 1'b0; mem_finish = 1'b0; roll_back = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
